// File: rtl/sysarr_row_loader.sv
// Scratchpad-to-systolic-array row sequencer: fetches weight, input and
// partial-sum rows for one GEMM at a time and replays them as row strobes.
module sysarr_row_loader #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 10,
    localparam int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            nRST,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_load_w,
    input  logic [AW-1:0]   cmd_w_base,
    input  logic [AW-1:0]   cmd_in_base,
    input  logic [AW-1:0]   cmd_ps_base,
    input  logic            sp_ready,
    output logic            sp_ren,
    output logic [AW-1:0]   sp_addr,
    input  logic [N*DW-1:0] sp_rdata,
    input  logic            fifo_has_space,
    input  logic            array_idle,
    output logic            weight_en,
    output logic            input_en,
    output logic            partial_en,
    output logic [RW-1:0]   row_in_en,
    output logic [RW-1:0]   row_ps_en,
    output logic [N*DW-1:0] in_row_data,
    output logic [N*DW-1:0] ps_row_data,
    output logic            busy,
    output logic            gemm_done
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WEIGHT     = 3'd1;
    localparam logic [2:0] WAIT_SPACE = 3'd2;
    localparam logic [2:0] INPUT      = 3'd3;
    localparam logic [2:0] PARTIAL    = 3'd4;

    localparam logic [1:0] T_W = 2'd0;
    localparam logic [1:0] T_I = 2'd1;
    localparam logic [1:0] T_P = 2'd2;

    localparam logic [RW-1:0] LAST = RW'(N - 1);

    logic [2:0]    state;
    logic [RW-1:0] r;
    logic [AW-1:0] w_base;
    logic [AW-1:0] in_base;
    logic [AW-1:0] ps_base;

    logic          tag_vld;
    logic [1:0]    tag_type;
    logic [RW-1:0] tag_row;
    logic          tag_last;

    logic          acc;
    logic          rd_last;
    logic          in_stb;

    always_comb begin
        sp_ren  = 1'b0;
        sp_addr = '0;
        case (state)
            WEIGHT: begin
                sp_ren  = array_idle;
                sp_addr = w_base + AW'(r);
            end
            INPUT: begin
                sp_ren  = 1'b1;
                sp_addr = in_base + AW'(r);
            end
            PARTIAL: begin
                sp_ren  = 1'b1;
                sp_addr = ps_base + AW'(r);
            end
            default: begin
                sp_ren  = 1'b0;
                sp_addr = '0;
            end
        endcase
    end

    assign acc     = sp_ren && sp_ready;
    assign rd_last = (r == LAST);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            r        <= '0;
            w_base   <= '0;
            in_base  <= '0;
            ps_base  <= '0;
            tag_vld  <= 1'b0;
            tag_type <= T_W;
            tag_row  <= '0;
            tag_last <= 1'b0;
        end else begin
            // Every accepted read leaves a tag describing the row returning next cycle.
            tag_vld  <= acc;
            tag_row  <= r;
            tag_last <= rd_last;
            tag_type <= (state == WEIGHT) ? T_W :
                        (state == INPUT)  ? T_I : T_P;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        w_base  <= cmd_w_base;
                        in_base <= cmd_in_base;
                        ps_base <= cmd_ps_base;
                        r       <= '0;
                        state   <= cmd_load_w ? WEIGHT : WAIT_SPACE;
                    end
                end
                WEIGHT: begin
                    if (acc) begin
                        r <= rd_last ? '0 : r + 1'b1;
                        if (rd_last) state <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (fifo_has_space) state <= INPUT;
                end
                INPUT: begin
                    if (acc) begin
                        r <= rd_last ? '0 : r + 1'b1;
                        if (rd_last) state <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (acc) begin
                        r <= rd_last ? '0 : r + 1'b1;
                        if (rd_last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE) || tag_vld;

    assign weight_en  = tag_vld && (tag_type == T_W);
    assign input_en   = tag_vld && (tag_type == T_I);
    assign partial_en = tag_vld && (tag_type == T_P);
    assign in_stb     = weight_en || input_en;

    assign row_in_en   = in_stb ? tag_row : '0;
    assign in_row_data = in_stb ? sp_rdata : '0;
    assign row_ps_en   = partial_en ? tag_row : '0;
    assign ps_row_data = partial_en ? sp_rdata : '0;
    assign gemm_done   = partial_en && tag_last;

endmodule

// File: tb/tb_sysarr_row_loader.sv
// Scoreboard bench for sysarr_row_loader: expected reads and strobes are
// queued at command issue and retired by a negedge monitor.
module tb_sysarr_row_loader;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int RW  = 2;
    localparam int RDW = N * DW;

    logic            clk = 1'b0;
    logic            nRST = 1'b0;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_load_w;
    logic [AW-1:0]   cmd_w_base;
    logic [AW-1:0]   cmd_in_base;
    logic [AW-1:0]   cmd_ps_base;
    logic            sp_ready;
    logic            sp_ren;
    logic [AW-1:0]   sp_addr;
    logic [RDW-1:0]  sp_rdata = '0;
    logic            fifo_has_space;
    logic            array_idle;
    logic            weight_en;
    logic            input_en;
    logic            partial_en;
    logic [RW-1:0]   row_in_en;
    logic [RW-1:0]   row_ps_en;
    logic [RDW-1:0]  in_row_data;
    logic [RDW-1:0]  ps_row_data;
    logic            busy;
    logic            gemm_done;

    sysarr_row_loader #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load_w(cmd_load_w), .cmd_w_base(cmd_w_base),
        .cmd_in_base(cmd_in_base), .cmd_ps_base(cmd_ps_base),
        .sp_ready(sp_ready), .sp_ren(sp_ren), .sp_addr(sp_addr),
        .sp_rdata(sp_rdata), .fifo_has_space(fifo_has_space),
        .array_idle(array_idle), .weight_en(weight_en),
        .input_en(input_en), .partial_en(partial_en),
        .row_in_en(row_in_en), .row_ps_en(row_ps_en),
        .in_row_data(in_row_data), .ps_row_data(ps_row_data),
        .busy(busy), .gemm_done(gemm_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int             kind;
        int             row;
        logic [RDW-1:0] data;
        bit             done;
        int             at;
    } exp_t;

    exp_t          sq[$];
    logic [AW-1:0] aq[$];
    int checks = 0;
    int fails  = 0;

    function automatic logic [RDW-1:0] memfn(logic [AW-1:0] a);
        return {6'h28, a, 6'h2c, a, 6'h30, a, 6'h34, a};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Scratchpad model: data returns one cycle after an accepted read.
    always @(posedge clk) begin
        if (sp_ren && sp_ready) sp_rdata <= memfn(sp_addr);
        else sp_rdata <= {N{16'hDEAD}};
    end

    exp_t e;
    int   mk;
    logic acc_prev = 1'b0;

    always @(negedge clk) begin
        if (sp_ren && sp_ready) begin
            if (aq.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_read at cycle %0d: got addr %0d expected none",
                         cyc, sp_addr);
            end else begin
                chk("read_addr", 64'(sp_addr), 64'(aq.pop_front()));
            end
        end
        if ($countones({weight_en, input_en, partial_en}) > 1) begin
            checks++; fails++;
            $display("FAIL strobe_onehot at cycle %0d: got %b expected one-hot",
                     cyc, {weight_en, input_en, partial_en});
        end else if (weight_en || input_en || partial_en) begin
            mk = weight_en ? 0 : input_en ? 1 : 2;
            if (sq.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_strobe at cycle %0d: got kind %0d expected none",
                         cyc, mk);
            end else begin
                e = sq.pop_front();
                chk("strobe_kind", 64'(mk), 64'(e.kind));
                chk("strobe_row",
                    64'(mk == 2 ? row_ps_en : row_in_en), 64'(e.row));
                chk("strobe_data",
                    64'(mk == 2 ? ps_row_data : in_row_data), 64'(e.data));
                chk("gemm_done", 64'(gemm_done), 64'(e.done));
                chk("strobe_lag", 64'(acc_prev), 64'(1));
                if (e.at >= 0) chk("strobe_cycle", 64'(cyc), 64'(e.at));
            end
        end else begin
            chk("gemm_done_idle", 64'(gemm_done), 64'(0));
        end
        if (!(weight_en || input_en)) begin
            chk("in_bus_idle", 64'({row_in_en, in_row_data}), 64'(0));
        end
        if (!partial_en) begin
            chk("ps_bus_idle", 64'({row_ps_en, ps_row_data}), 64'(0));
        end
        acc_prev = sp_ren && sp_ready && nRST;
    end

    task automatic at_cycle(int t);
        repeat (300) begin
            if (cyc >= t && clk == 1'b0) break;
            @(negedge clk);
        end
    endtask

    task automatic run_cmd(bit lw, logic [AW-1:0] wb, logic [AW-1:0] ib,
                           logic [AW-1:0] pb, int wo[4], int io[4],
                           int po[4], int n_ps, int n_pstb,
                           output int c0);
        exp_t x;
        cmd_load_w  = lw;
        cmd_w_base  = wb;
        cmd_in_base = ib;
        cmd_ps_base = pb;
        cmd_valid   = 1'b1;
        c0 = -1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                c0 = cyc;
                break;
            end
            @(negedge clk);
        end
        if (c0 < 0) begin
            fails++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1");
            $fatal(1, "command never accepted");
        end
        for (int r = 0; r < N; r++) begin
            if (lw) begin
                aq.push_back(wb + AW'(r));
                x = '{0, r, memfn(wb + AW'(r)), 1'b0,
                      wo[r] < 0 ? -1 : c0 + wo[r]};
                sq.push_back(x);
            end
        end
        for (int r = 0; r < N; r++) begin
            aq.push_back(ib + AW'(r));
            x = '{1, r, memfn(ib + AW'(r)), 1'b0,
                  io[r] < 0 ? -1 : c0 + io[r]};
            sq.push_back(x);
        end
        for (int r = 0; r < n_ps; r++) aq.push_back(pb + AW'(r));
        for (int r = 0; r < n_pstb; r++) begin
            x = '{2, r, memfn(pb + AW'(r)), r == N - 1,
                  po[r] < 0 ? -1 : c0 + po[r]};
            sq.push_back(x);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sq.size() != 0 || aq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queues", 64'(sq.size() + aq.size()), 64'(0));
    endtask

    int c0;
    int nw[4]   = '{-1, -1, -1, -1};
    int std_i[4] = '{3, 4, 5, 6};
    int std_p[4] = '{7, 8, 9, 10};

    initial begin
        cmd_valid = 1'b1;
        cmd_load_w = 1'b0;
        cmd_w_base = '0;
        cmd_in_base = '0;
        cmd_ps_base = '0;
        sp_ready = 1'b1;
        fifo_has_space = 1'b1;
        array_idle = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("reset_strobes",
            64'({weight_en, input_en, partial_en, gemm_done}), 64'(0));
        chk("reset_sp_ren", 64'(sp_ren), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 nRST = 1'b1;
        @(posedge clk);
        #1;

        // Standard timeline, then a back-to-back command with wrapping addresses.
        run_cmd(0, 10'd0, 10'd100, 10'd200, nw, std_i, std_p, 4, 4, c0);
        at_cycle(c0 + 10);
        chk("t1_cmd_ready_c10", 64'(cmd_ready), 64'(1));
        chk("t1_busy_c10", 64'(busy), 64'(1));
        run_cmd(0, 10'd0, 10'd1022, 10'd500, nw, std_i, std_p, 4, 4, c0);
        at_cycle(c0 + 10);
        chk("wrap_cmd_ready_c10", 64'(cmd_ready), 64'(1));
        drain();

        // Weights held off by array_idle until c5.
        @(posedge clk);
        #1 array_idle = 1'b0;
        run_cmd(1, 10'd300, 10'd40, 10'd60, '{6, 7, 8, 9},
                '{11, 12, 13, 14}, '{15, 16, 17, 18}, 4, 4, c0);
        for (int k = 1; k <= 4; k++) begin
            at_cycle(c0 + k);
            chk("w_sp_ren_held", 64'(sp_ren), 64'(0));
        end
        @(posedge clk);
        #1 array_idle = 1'b1;
        drain();

        // No space for 7 cycles; spurious command ignored; space drop in INPUT.
        @(posedge clk);
        #1 fifo_has_space = 1'b0;
        run_cmd(0, 10'd0, 10'd900, 10'd950, nw, '{10, 11, 12, 13},
                '{14, 15, 16, 17}, 4, 4, c0);
        cmd_valid = 1'b1;
        cmd_in_base = 10'd7;
        cmd_ps_base = 10'd7;
        for (int k = 1; k <= 7; k++) begin
            at_cycle(c0 + k);
            chk("ws_sp_ren", 64'(sp_ren), 64'(0));
            chk("ws_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        @(posedge clk);
        #1 fifo_has_space = 1'b1;
        cmd_valid = 1'b0;
        at_cycle(c0 + 10);
        fifo_has_space = 1'b0;
        drain();
        fifo_has_space = 1'b1;

        // sp_ready toggling during INPUT.
        @(posedge clk);
        #1;
        run_cmd(0, 10'd0, 10'd20, 10'd80, nw, '{3, 5, 7, 9},
                '{10, 11, 12, 13}, 4, 4, c0);
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk);
            #1 sp_ready = (k % 2 == 0);
        end
        drain();

        // Reset during PARTIAL with partial row 0 in flight.
        @(posedge clk);
        #1;
        run_cmd(0, 10'd0, 10'd600, 10'd700, nw, std_i, std_p, 1, 0, c0);
        at_cycle(c0 + 6);
        @(posedge clk);
        #1 nRST = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_partial_en", 64'(partial_en), 64'(0));
        repeat (2) @(posedge clk);
        #1 nRST = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_queues_empty", 64'(sq.size() + aq.size()), 64'(0));
        @(posedge clk);
        #1;
        run_cmd(0, 10'd0, 10'd123, 10'd456, nw, std_i, std_p, 4, 4, c0);
        at_cycle(c0 + 10);
        chk("post_rst_cmd_ready_c10", 64'(cmd_ready), 64'(1));
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
